// File: rtl/timing_engine_pkg.sv
// Shared timing-engine types and defaults: receive-enable FSM states, default
// cycle constants and the counter-width sanity check used at elaboration.
package timing_engine_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARMUP   = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } rx_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_WARMUP_CYCLES   = 8;
  localparam int DEF_COOLDOWN_CYCLES = 4;
  localparam int DEF_MAX_ON_CYCLES   = 1024;
  localparam int DEF_CNT_W           = 16;

  // True when a cnt_w-bit counter can represent every cycle constant.
  function automatic bit cnt_w_fits(int cnt_w, int warmup, int cooldown, int max_on);
    int largest;
    largest = warmup;
    if (cooldown > largest) largest = cooldown;
    if (max_on > largest) largest = max_on;
    return (cnt_w >= 31) || ((cnt_w >= 1) && (largest < (1 << cnt_w)));
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Level synchronizer: SYNC_STAGES flop chain into the local clock, async reset to 0.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ck,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) chain <= '0;
    else      chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/radio_rx_en_ctrl.sv
// Radio receive-enable sequencer: synchronized request -> warm-up -> active -> cool-down,
// with the M1/M3 isolation clamp. Define RADIO_RX_TIMEOUT_EN to add the active-window watchdog.
module radio_rx_en_ctrl
  import timing_engine_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic ck,
  input  logic arst,
  input  logic rx_req_async,
  input  logic isolateM1M3,
  output logic radio_pwr_en,
  output logic radioRxEnSynced,
  output logic rx_on_pulse,
  output logic busy,
  output logic rx_timeout
);

  if (!cnt_w_fits(CNT_W, WARMUP_CYCLES, COOLDOWN_CYCLES, MAX_ON_CYCLES)) begin : g_bad_cnt_w
    $error("radio_rx_en_ctrl: CNT_W too narrow for the cycle parameters");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("radio_rx_en_ctrl: SYNC_STAGES must be 2..4");
  end

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'((MAX_ON_CYCLES > 0) ? MAX_ON_CYCLES - 1 : 0);

  // Zero-length phases are skipped at elaboration so the counter never wraps.
  localparam rx_state_e        ARM_STATE  = (WARMUP_CYCLES > 0) ? WARMUP : ACTIVE;
  localparam logic [CNT_W-1:0] ARM_LOAD   = (WARMUP_CYCLES > 0) ? WARM_LOAD : ON_LOAD;
  localparam rx_state_e        EXIT_STATE = (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;

  logic             req_s;
  rx_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
`ifdef RADIO_RX_TIMEOUT_EN
  logic             timeout_hit;
`endif

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .ck   (ck),
    .arst (arst),
    .d    (rx_req_async),
    .q    (req_s)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
`ifdef RADIO_RX_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req_s && !isolateM1M3 && !rx_timeout) begin
          state_next = ARM_STATE;
          cnt_next   = ARM_LOAD;
        end
      end
      WARMUP: begin
        if (isolateM1M3 || !req_s) begin
          state_next = EXIT_STATE;
          cnt_next   = COOL_LOAD;
        end else if (cnt == '0) begin
          state_next = ACTIVE;
          cnt_next   = ON_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (isolateM1M3 || !req_s) begin
          state_next = EXIT_STATE;
          cnt_next   = COOL_LOAD;
        end
`ifdef RADIO_RX_TIMEOUT_EN
        else if (cnt == '0) begin
          state_next  = EXIT_STATE;
          cnt_next    = COOL_LOAD;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
`endif
      end
      COOLDOWN: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CNT_ONE;
      end
    endcase
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_on_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rx_on_pulse <= (state_next == ACTIVE) && (state != ACTIVE);
    end
  end

`ifdef RADIO_RX_TIMEOUT_EN
  // Sticky until the requester lets go, so a stuck request cannot re-arm the radio.
  always_ff @(posedge ck or posedge arst) begin
    if (arst)                           rx_timeout <= 1'b0;
    else if (timeout_hit)               rx_timeout <= 1'b1;
    else if (state == IDLE && !req_s)   rx_timeout <= 1'b0;
  end
`else
  assign rx_timeout = 1'b0;
`endif

  // The clamp gates the registered decodes combinationally so isolation bites this cycle.
  assign radio_pwr_en    = ((state == WARMUP) || (state == ACTIVE)) && !isolateM1M3;
  assign radioRxEnSynced = (state == ACTIVE) && !isolateM1M3;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_radio_rx_en_ctrl.sv
// Scoreboard bench for radio_rx_en_ctrl: stimulus pushes expected output changes
// (cycle + value), a negedge monitor pops one per observed change and compares.
module tb_radio_rx_en_ctrl;

  // Output vector order: {rx_timeout, busy, rx_on_pulse, radioRxEnSynced, radio_pwr_en}
  localparam logic [4:0] O_IDLE    = 5'b00000;
  localparam logic [4:0] O_WARM    = 5'b01001;
  localparam logic [4:0] O_ON1     = 5'b01111;
  localparam logic [4:0] O_ON      = 5'b01011;
  localparam logic [4:0] O_COOL    = 5'b01000;
  localparam logic [4:0] O_TO_COOL = 5'b11000;
  localparam logic [4:0] O_TO_IDLE = 5'b10000;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [4:0] outs;
    string      tag;
  } exp_t;

  exp_t q_m[$];
  exp_t q_z[$];
  exp_t q_t[$];

  // main DUT (defaults), zero-length-phase DUT, watchdog DUT
  logic arst_m, req_m, iso_m, pwr_m, rxen_m, pulse_m, busy_m, to_m;
  logic arst_z, req_z, iso_z, pwr_z, rxen_z, pulse_z, busy_z, to_z;
  logic arst_t, req_t, iso_t, pwr_t, rxen_t, pulse_t, busy_t, to_t;

  radio_rx_en_ctrl dut_m (
    .ck(ck), .arst(arst_m), .rx_req_async(req_m), .isolateM1M3(iso_m),
    .radio_pwr_en(pwr_m), .radioRxEnSynced(rxen_m), .rx_on_pulse(pulse_m),
    .busy(busy_m), .rx_timeout(to_m)
  );

  radio_rx_en_ctrl #(.WARMUP_CYCLES(0), .COOLDOWN_CYCLES(0)) dut_z (
    .ck(ck), .arst(arst_z), .rx_req_async(req_z), .isolateM1M3(iso_z),
    .radio_pwr_en(pwr_z), .radioRxEnSynced(rxen_z), .rx_on_pulse(pulse_z),
    .busy(busy_z), .rx_timeout(to_z)
  );

  radio_rx_en_ctrl #(.MAX_ON_CYCLES(16)) dut_t (
    .ck(ck), .arst(arst_t), .rx_req_async(req_t), .isolateM1M3(iso_t),
    .radio_pwr_en(pwr_t), .radioRxEnSynced(rxen_t), .rx_on_pulse(pulse_t),
    .busy(busy_t), .rx_timeout(to_t)
  );

  task automatic check(string name, logic [4:0] act, logic [4:0] exp_v, int act_c, int exp_c);
    checks++;
    if (act !== exp_v || (exp_c >= 0 && act_c != exp_c)) begin
      errors++;
      $display("FAIL %s: got outs=%b at cycle %0d, expected outs=%b at cycle %0d",
               name, act, act_c, exp_v, exp_c);
    end
  endtask

  task automatic expect_at(int idx, int c, logic [4:0] v, string tag);
    exp_t e;
    e.cyc  = c;
    e.outs = v;
    e.tag  = tag;
    case (idx)
      0:       q_m.push_back(e);
      1:       q_z.push_back(e);
      default: q_t.push_back(e);
    endcase
  endtask

  bit         seen [3];
  logic [4:0] prev [3];

  task automatic observe(int idx, logic [4:0] outs);
    exp_t e;
    bit   have;
    logic [4:0] old;
    if (seen[idx] && outs === prev[idx]) return;
    old       = prev[idx];
    seen[idx] = 1'b1;
    prev[idx] = outs;
    have      = 1'b0;
    case (idx)
      0:       if (q_m.size() > 0) begin e = q_m.pop_front(); have = 1'b1; end
      1:       if (q_z.size() > 0) begin e = q_z.pop_front(); have = 1'b1; end
      default: if (q_t.size() > 0) begin e = q_t.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      check($sformatf("dut%0d_%s", idx, e.tag), outs, e.outs, cyc, e.cyc);
    end else begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_change: got outs=%b at cycle %0d, expected no change from %b",
               idx, outs, cyc, old);
    end
  endtask

  always @(negedge ck) begin
    observe(0, {to_m, busy_m, pulse_m, rxen_m, pwr_m});
    observe(1, {to_z, busy_z, pulse_z, rxen_z, pwr_z});
    observe(2, {to_t, busy_t, pulse_t, rxen_t, pwr_t});
  end

  // Drive point: 2 time units after the posedge that makes cyc == c.
  task automatic go(int c);
    while (cyc != c) begin
      @(posedge ck);
      #2;
    end
  endtask

  task automatic seq_main();
    // full window with default parameters
    go(4);   req_m = 1'b1;
    expect_at(0, 7,  O_WARM, "pwr_rise");
    expect_at(0, 15, O_ON1,  "rxen_rise");
    expect_at(0, 16, O_ON,   "pulse_end");
    go(54);  req_m = 1'b0;
    expect_at(0, 57, O_COOL, "enables_fall");
    expect_at(0, 61, O_IDLE, "cool_done");
    // abort during warm-up, then minimum-off gap before re-rise
    go(70);  req_m = 1'b1;
    expect_at(0, 73, O_WARM, "abort_warm");
    go(76);  req_m = 1'b0;
    expect_at(0, 79, O_COOL, "abort_cool");
    go(80);  req_m = 1'b1;
    expect_at(0, 83, O_IDLE, "abort_idle");
    expect_at(0, 84, O_WARM, "rearm_gap");
    expect_at(0, 92, O_ON1,  "rearm_active");
    expect_at(0, 93, O_ON,   "rearm_pulse_end");
    // isolation pulse in ACTIVE
    go(100); iso_m = 1'b1;
    expect_at(0, 100, O_COOL, "iso_clamp_same_cycle");
    go(101); iso_m = 1'b0;
    expect_at(0, 105, O_IDLE, "iso_cool_done");
    expect_at(0, 106, O_WARM, "iso_rearm");
    go(107); req_m = 1'b0;
    expect_at(0, 110, O_COOL, "drop_warm");
    expect_at(0, 114, O_IDLE, "drop_idle");
    // isolation held in IDLE with request high blocks arming
    go(112); iso_m = 1'b1; req_m = 1'b1;
    go(130); iso_m = 1'b0;
    expect_at(0, 131, O_WARM, "iso_idle_release");
    go(132); req_m = 1'b0;
    expect_at(0, 135, O_COOL, "iso_idle_drop");
    expect_at(0, 139, O_IDLE, "iso_idle_done");
    // asynchronous reset mid-ACTIVE
    go(150); req_m = 1'b1;
    expect_at(0, 153, O_WARM, "pre_arst_warm");
    expect_at(0, 161, O_ON1,  "pre_arst_active");
    expect_at(0, 162, O_ON,   "pre_arst_pulse_end");
    go(170); arst_m = 1'b1;
    expect_at(0, 170, O_IDLE, "arst_async_clear");
    go(173); arst_m = 1'b0;
    expect_at(0, 176, O_WARM, "arst_refill");
    go(177); req_m = 1'b0;
    expect_at(0, 180, O_COOL, "post_arst_cool");
    expect_at(0, 184, O_IDLE, "post_arst_idle");
  endtask

  task automatic seq_zero();
    go(4);  req_z = 1'b1;
    expect_at(1, 7,  O_ON1,  "z_direct_active");
    expect_at(1, 8,  O_ON,   "z_pulse_end");
    go(20); req_z = 1'b0;
    expect_at(1, 23, O_IDLE, "z_direct_idle");
    go(30); req_z = 1'b1;
    expect_at(1, 33, O_ON1,  "z_second_active");
    expect_at(1, 34, O_ON,   "z_second_pulse_end");
    go(36); req_z = 1'b0;
    expect_at(1, 39, O_IDLE, "z_second_idle");
  endtask

  task automatic seq_to();
    go(4);  req_t = 1'b1;
    expect_at(2, 7,  O_WARM, "t_warm");
    expect_at(2, 15, O_ON1,  "t_active");
    expect_at(2, 16, O_ON,   "t_pulse_end");
`ifdef RADIO_RX_TIMEOUT_EN
    expect_at(2, 31, O_TO_COOL, "t_watchdog_fall");
    expect_at(2, 35, O_TO_IDLE, "t_no_rearm");
    go(60); req_t = 1'b0;
    expect_at(2, 63, O_IDLE,    "t_flag_clear");
`else
    go(60); req_t = 1'b0;
    expect_at(2, 63, O_COOL, "t_unbounded_drop");
    expect_at(2, 67, O_IDLE, "t_unbounded_idle");
`endif
  endtask

  task automatic check_drained(string name, int left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL %s_missing_events: got %0d expected changes never seen, required 0", name, left);
    end
  endtask

  initial begin
    arst_m = 1'b1; arst_z = 1'b1; arst_t = 1'b1;
    req_m  = 1'b0; req_z  = 1'b0; req_t  = 1'b0;
    iso_m  = 1'b0; iso_z  = 1'b0; iso_t  = 1'b0;
    expect_at(0, -1, O_IDLE, "reset_state");
    expect_at(1, -1, O_IDLE, "reset_state");
    expect_at(2, -1, O_IDLE, "reset_state");
    go(2);
    arst_m = 1'b0; arst_z = 1'b0; arst_t = 1'b0;
    fork
      seq_main();
      seq_zero();
      seq_to();
    join
    go(200);
    check_drained("dut0", q_m.size());
    check_drained("dut1", q_z.size());
    check_drained("dut2", q_t.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
